add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_if.sv | 27 ++
 rtl/add_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/add_arbiter_if.sv
// Request/response bundle for the shared adder: requester side is master, arbiter is slave.
interface add_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 31
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface

// File: rtl/add_arbiter.sv
// Shared two-stage signed adder with an NREQ-way arbiter in front of it.
// Round-robin by default; define ADD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer).
module add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 31
) (
    input  logic         clk,
    input  logic         rst,
    add_arbiter_if.slave bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            stall_c;
    logic            fire_c;
    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  gnt_id_c;
    logic [IDW-1:0]  scan_idx_c;

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W:0]      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            busy_q, busy_d;
`ifndef ADD_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  ptr_q, ptr_d;
`endif

    // Whole pipeline freezes while a result waits for the consumer.
    assign stall_c = rsp_valid_q & ~bus.rsp_ready;

    // Arbiter: first requester found scanning upward (from ptr, with wrap).
    always_comb begin
        gnt_c      = '0;
        gnt_id_c   = '0;
        fire_c     = 1'b0;
        scan_idx_c = '0;
        if (!rst && !stall_c) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
                scan_idx_c = IDW'(k);
`else
                scan_idx_c = ptr_q + IDW'(k);
`endif
                if (!fire_c && bus.req[scan_idx_c]) begin
                    fire_c            = 1'b1;
                    gnt_id_c          = scan_idx_c;
                    gnt_c[scan_idx_c] = 1'b1;
                end
            end
        end
    end

    // Next state for both stages and the pointer; everything holds on stall.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
`ifndef ADD_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        if (!stall_c) begin
            s1_valid_d = fire_c;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_c[i]) begin
                    s1_a_d = bus.req_a[i*W +: W];
                    s1_b_d = bus.req_b[i*W +: W];
                end
            end
            if (fire_c) begin
                s1_id_d = gnt_id_c;
`ifndef ADD_ARB_FIXED_PRIO_EN
                ptr_d   = gnt_id_c + IDW'(1);
`endif
            end
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_sum_d = {s1_a_q[W-1], s1_a_q} + {s1_b_q[W-1], s1_b_q};
                rsp_id_d  = s1_id_q;
            end
        end
        busy_d = s1_valid_d | rsp_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
`ifndef ADD_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
`ifndef ADD_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

endmodule
